// File: rtl/aes_pkg.sv
// Shared AES helpers: FSM state encoding, round constants and the forward S-box.
// The encryption key schedule imports the same S-box table.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Index 0 has no round constant; it maps to zero so an idle lookup is harmless.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: applies the AES S-box independently to each byte of a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_inv_key_sch.sv
// AES-128 decryption key scheduler: expands to K10 in one register, then
// steps backwards one round key per handshake down to K0.
module aes_inv_key_sch
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] master_key_i,
  output logic         busy_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_nr_o,
  output logic         done_o
);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, sub_out, t;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] fwd_key, inv_key;
  logic         xfer;

  assign {w0, w1, w2, w3} = key_q;
  assign xfer = valid_q & key_ready_i;

  // The inverse step needs SubWord of the recovered w3 (w3^w2); one S-box bank serves both.
  assign sub_in = (state_q == OUTPUT) ? (w3 ^ w2) : w3;

  aes_subword u_subword (
    .word_i (rot_word(sub_in)),
    .word_o (sub_out)
  );

  assign t  = sub_out ^ {rcon(rnd_q), 24'h0};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};
  assign inv_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          key_d   = master_key_i;
          rnd_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        key_d = fwd_key;
        // rnd is left at 10 on exit, which is exactly the first round to output.
        if (rnd_q == 4'd10) state_d = OUTPUT;
        else                rnd_d   = rnd_q + 4'd1;
      end
      OUTPUT: begin
        if (xfer) begin
          if (rnd_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = inv_key;
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == OUTPUT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign key_valid_o = valid_q;
  assign done_o      = done_q;
  assign round_key_o = key_q;
  assign round_nr_o  = rnd_q;

endmodule

// File: tb/tb_aes_inv_key_sch.sv
// Directed bench for the AES-128 inverse key scheduler using FIPS-197 round keys.
module tb_aes_inv_key_sch;

  logic         clk = 1'b0;
  logic         rst_i, start_i, key_ready_i;
  logic [127:0] master_key_i;
  logic         busy_o, key_valid_o, done_o;
  logic [127:0] round_key_o;
  logic [3:0]   round_nr_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [127:0] exp_k  [0:10];
  bit           exp_ok [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  aes_inv_key_sch dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .master_key_i (master_key_i),
    .busy_o       (busy_o),
    .key_valid_o  (key_valid_o),
    .key_ready_i  (key_ready_i),
    .round_key_o  (round_key_o),
    .round_nr_o   (round_nr_o),
    .done_o       (done_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  128'(busy_o),      128'd0);
    chk({tag, ".valid"}, 128'(key_valid_o), 128'd0);
    chk({tag, ".done"},  128'(done_o),      128'd0);
    chk({tag, ".nr"},    128'(round_nr_o),  128'd0);
    chk({tag, ".key"},   round_key_o,       128'd0);
  endtask

  task automatic set_fips();
    exp_k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i <= 10; i++) exp_ok[i] = 1'b1;
  endtask

  task automatic set_zero();
    for (int i = 0; i <= 10; i++) exp_ok[i] = 1'b0;
    exp_k[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e; exp_ok[10] = 1'b1;
    exp_k[0]  = 128'h0;                               exp_ok[0]  = 1'b1;
  endtask

  task automatic start_key(input logic [127:0] key);
    start_i      = 1'b1;
    master_key_i = key;
    tick();
    start_i      = 1'b0;
    master_key_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Full schedule; poke drives start_i with another key during EXPAND, OUTPUT and the K0 transfer.
  task automatic run(input string tag, input logic [127:0] key, input int stall_pct, input bit poke);
    int cyc, r, xfers, edges;
    start_key(key);
    chk({tag, ".busy_on"}, 128'(busy_o), 128'd1);
    cyc = 0;
    while (!key_valid_o && cyc < 20) begin
      key_ready_i = $urandom_range(0, 1) != 0;
      if (poke && cyc == 4) begin start_i = 1'b1; master_key_i = ~key; end
      tick();
      start_i = 1'b0;
      cyc++;
    end
    chk({tag, ".latency"}, 128'(cyc), 128'd10);
    edges = cyc; r = 10; xfers = 0;
    while (r >= 0 && edges < 400) begin
      key_ready_i = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
      if (poke && (r == 5 || r == 0)) begin start_i = 1'b1; master_key_i = ~key; end
      chk($sformatf("%s.valid%0d", tag, r), 128'(key_valid_o), 128'd1);
      if (!key_valid_o) break;
      chk($sformatf("%s.nr%0d", tag, r), 128'(round_nr_o), 128'(r));
      if (exp_ok[r]) chk($sformatf("%s.k%0d", tag, r), round_key_o, exp_k[r]);
      tick();
      start_i = 1'b0;
      edges++;
      if (key_ready_i) begin r--; xfers++; end
    end
    chk({tag, ".xfers"},    128'(xfers),       128'd11);
    chk({tag, ".done"},     128'(done_o),      128'd1);
    chk({tag, ".valid_end"},128'(key_valid_o), 128'd0);
    chk({tag, ".busy_end"}, 128'(busy_o),      128'd0);
    // 21 edges after the accepting edge: done is seen in the 22nd cycle counting the start cycle.
    if (stall_pct == 0) chk({tag, ".start2done"}, 128'(edges), 128'd21);
  endtask

  task automatic abort_at(input string tag, input bit in_output);
    int cyc;
    cyc = 0;
    key_ready_i = 1'b1;
    start_key(FIPS_KEY);
    if (!in_output) begin
      repeat (4) tick();
      chk({tag, ".mid_expand"}, 128'({busy_o, key_valid_o}), 128'b10);
    end else begin
      while (!(key_valid_o && round_nr_o == 4'd6) && cyc < 40) begin tick(); cyc++; end
      chk({tag, ".at_r6"}, 128'(round_nr_o), 128'd6);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_idle(tag);
    tick();
    chk({tag, ".no_done"}, 128'(done_o), 128'd0);
    chk({tag, ".stay_idle"}, 128'(busy_o), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; key_ready_i = 1'b0; master_key_i = '0;
    repeat (3) tick();
    chk_idle("reset");
    rst_i = 1'b0;
    tick();

    set_fips();
    run("fips", FIPS_KEY, 0, 1'b0);
    set_zero();
    run("zero_b2b", 128'h0, 0, 1'b0);
    set_fips();
    run("stall", FIPS_KEY, 40, 1'b0);
    run("poke", FIPS_KEY, 0, 1'b1);
    tick();
    abort_at("rst_exp", 1'b0);
    run("fresh1", FIPS_KEY, 0, 1'b0);
    abort_at("rst_out", 1'b1);
    run("fresh2", FIPS_KEY, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sch.md
# aes_inv_key_sch

- Decryption-side AES-128 key scheduler: delivers round keys in reverse order, K10 down to K0, to the inverse cipher datapath.
- Forward-expands the master key to K10 internally, then walks the schedule backwards one key per accepted handshake.
- Needs only one 128-bit key register; no key RAM.
- Sits beside the encryption key schedule and feeds the AddRoundKey stage of the decryption core.

## Interface
Parameters: none (AES-128 only).
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  load request; sampled only while busy_o=0
- master_key_i  in  128  cipher key, sampled with start_i; word w0 = [127:96]
- busy_o  out  1  high from the cycle after start is accepted until the K0 transfer
- key_valid_o  out  1  round_key_o/round_nr_o hold a valid key
- key_ready_i  in  1  consumer accepts the key; transfer = key_valid_o & key_ready_i
- round_key_o  out  128  current round key, registered
- round_nr_o  out  4  round index of round_key_o (10..0)
- done_o  out  1  one-cycle pulse in the cycle after K0 transfers

## Operation
- States: IDLE, EXPAND, OUTPUT.
- IDLE: on start_i=1, key_reg <= master_key_i, cnt <= 1, go to EXPAND.
- EXPAND: each cycle key_reg <= fwd(key_reg, rcon(cnt)), cnt++. When cnt=10 is processed, go to OUTPUT with rnd <= 10. key_ready_i is ignored.
- OUTPUT: key_valid_o=1, round_key_o=key_reg, round_nr_o=rnd.
  - Transfer with rnd>0: key_reg <= inv(key_reg, rcon(rnd)), rnd--.
  - Transfer with rnd=0: go to IDLE, done_o=1 next cycle, key_valid_o=0.
  - No transfer: hold key_reg and rnd stable.
- Forward step, FIPS-197: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- Inverse step: w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^{rcon,24'h0}.
- RotWord = {b[23:0], b[31:24]}.
- rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36. rcon is never looked up with index 0.
- start_i while busy_o=1 is ignored. master_key_i is don't-care outside the accept cycle.
- start_i in the same cycle as the K0 transfer is ignored. A new start is accepted from IDLE on the next cycle.

## Timing
- Reset values: busy_o=0, key_valid_o=0, done_o=0, round_nr_o=0, round_key_o=0, state=IDLE.
- rst_i asserted mid-EXPAND or mid-OUTPUT: outputs return to reset values at the next edge. The in-flight schedule is discarded with no done_o.
- Start accepted at edge t: busy_o=1 from t. EXPAND occupies edges t+1..t+10. key_valid_o=1 with K10 in the cycle after edge t+10, i.e. 10 cycles of latency.
- With key_ready_i held high, one key per cycle: K10..K0 over 11 consecutive cycles, then done_o.
- Total start-to-done with no backpressure: 22 cycles.
- All outputs are registered. key_ready_i does not reach any output combinationally.

## Structure
- Package aes_pkg holds:
  - state enum (IDLE/EXPAND/OUTPUT),
  - rcon lookup function,
  - S-box function/table, shared with the encryption key schedule.
- Sub-module aes_subword: 32-bit SubWord, four S-box lookups.
  - Exactly one instance.
  - Input muxed: w3 of key_reg in EXPAND, w3^w2 in OUTPUT.
- One shared step datapath selected by state; no duplicated S-boxes.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c, key_ready_i=1:
  - K10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at 10 cycles;
  - K9 = ac7766f319fadc2128d12941575c006e;
  - K1 = a0fafe1788542cb123a339392a6c7605;
  - K0 = master key;
  - done_o at cycle 22.
- All-zero key: K10 = b4ef5bcb3e92e21123e951cf6f8f188e, K0 = 0.
- Random backpressure on key_ready_i:
  - round_key_o and round_nr_o stable while valid & !ready;
  - sequence identical to the no-stall run;
  - exactly 11 transfers.
- start_i pulsed during EXPAND and OUTPUT with a different key: ignored, original sequence unchanged.
- rst_i at EXPAND cycle 5 and again with OUTPUT at round 6:
  - all outputs zero next cycle, no done_o;
  - a fresh start completes correctly.
- Back-to-back: start_i asserted in the done_o cycle is accepted; second key's K10 appears 10 cycles later.
